selfcon_ctrl: RTL
=================

# selfcon_ctrl

On-chip self-convergence controller for the BISG test path. It sits on the far side of `BISG_TOP` from the stimulus side: it consumes the `over`, `scan_done`, `sig` and `speed` results of each BIST run and drives the next run's `rst_n`, `start` and `ScanNum`. Runs repeat until the captured worst-case delay has converged `K` times or the run budget is exhausted. Signature pass/fail against a self-captured golden signature is tracked per run.

## Interface
Parameters:
- `SIG_W`, 13, signature width
- `SCAN_W`, 20, ScanNum width
- `SPEED_W`, 10, speed code width
- `DMAX_W`, 14, converted delay width (ps)
- `SCAN_START`, 60, ScanNum of first run
- `SCAN_BASE`, 10, ScanNum increment unit
- `K`, 8, qualifying steps required for convergence
- `EPS`, 10, convergence threshold (ps)
- `MAX_RUNS`, 24, run budget
- `RST_CYC`, 3, cycles `bist_rst_n` is held low per run

Ports:
- `clk` in 1: single clock; all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `go` in 1: start a convergence sequence (sampled in IDLE only)
- `abort` in 1: synchronous abort to IDLE
- `over` in 1: BIST run complete
- `scan_done` in 1: scan chain unload complete
- `sig` in SIG_W: MISR signature
- `speed` in SPEED_W: captured speed code
- `bist_rst_n` out 1: drives CUT `rst_n`
- `bist_start` out 1: drives CUT `start`
- `scan_num` out SCAN_W: drives CUT `ScanNum`
- `pass` out 1: current signature matches golden
- `sig_err` out 1: sticky; a mismatch was seen in this sequence
- `golden_sig` out SIG_W: captured golden signature
- `dmax` out DMAX_W: delay of last completed run
- `run_cnt` out 5: completed runs
- `conv_cnt` out 4: qualifying steps
- `done` out 1: level; sequence finished
- `converged` out 1: valid when `done`

## Operation
- Reset values: `bist_rst_n`=1, `bist_start`=0, `scan_num`=SCAN_START, `golden_sig`=0, `dmax`=0, counters 0, all flags 0, multiplier=1, state IDLE.
- States: IDLE → RST_LO → WAIT_LO → RUN → EVAL → NEXT → (RST_LO | DONE).
- IDLE: `go`=1 clears counters, `sig_err`, `done`, `converged`, sets multiplier=1 and `scan_num`=SCAN_START, then moves to RST_LO.
- RST_LO: `bist_rst_n`=0 for exactly RST_CYC cycles. `bist_start`=1 from RST_LO until DONE.
- WAIT_LO: waits until `over`=0.
- RUN: waits for the rising edge of `over`. Each rising edge of `scan_done` is one event. The first event in a run captures `sig` into `golden_sig` and sets `pass`=1. Later events set `pass` = (`sig`==`golden_sig`), and a mismatch sets `sig_err`. `pass` clears on entry to RST_LO.
- EVAL: `dmax` = (`speed`>20) ? 1000+10·`speed` : 900+10·`speed`, computed unsigned at DMAX_W. When `run_cnt`>0 and |new−previous `dmax`| ≤ EPS, the multiplier doubles (saturating at 1024) and `conv_cnt` increments. `run_cnt` increments.
- NEXT: terminates to DONE, with `scan_num` not updated, if `conv_cnt`==K (`converged`=1) or `run_cnt`==MAX_RUNS (`converged`=0). Otherwise `scan_num` += multiplier·SCAN_BASE and the state returns to RST_LO. If that add would overflow SCAN_W, `scan_num` clamps to all-ones and the state goes to DONE with `converged`=0.
- DONE: `done`=1 and `bist_start`=0, held until `go`, which starts a new sequence.
- `abort` in any state goes to IDLE next cycle. It restores the reset values except `sig_err`, `dmax` and counters, which are held for readout.

## Timing
- `go` to `bist_rst_n` low: 1 cycle.
- `over` rising edge sampled at cycle t: EVAL at t+1, `dmax` and counters valid at t+2, next `scan_num` or `done` valid at t+2.
- `pass` and `sig_err` update 1 cycle after the `scan_done` rising edge is sampled.
- If `scan_done` and `over` rise in the same cycle, the signature event is processed before EVAL.
- `rst` overrides `abort`, which overrides `go`.

## Structure
- `selfcon_pkg`: state enum, speed threshold 20, offsets 900/1000, scale 10, multiplier cap.
- Sub-module `selfcon_dmax_eval`: combinational speed→dmax conversion and |Δ|≤EPS compare. The FSM, counters and signature tracking stay in `selfcon_ctrl`.

## Test plan
- Reset: hold `rst`, then release. All outputs at the reset values listed above; `scan_num`=60.
- Constant `speed`=30 (dmax 1300): `scan_num` sequence 60, 70, 90, 130, 210, 370, 690, 1330, 2610. `done` after run 9 with `converged`=1, `conv_cnt`=8, final `scan_num`=2610.
- Alternating `speed` 20/21 (dmax 1100/1210, Δ=110): never qualifies. `done` after 24 runs with `converged`=0, `scan_num`=290.
- `scan_done` events in one run with `sig` 0x0A5, 0x0A5, 0x0A4: `golden_sig`=0x0A5 and `pass` 1, 1, 0; `sig_err`=1, remaining set through later runs.
- `abort`, then `rst`, each asserted during RUN of run 3: IDLE next cycle, `bist_start`=0, `bist_rst_n`=1. After `abort`, `run_cnt`=2 is held; after `rst`, all values return to reset.
- Speed boundary 20→1100 and 21→1210. Speed 1023 gives dmax 11230 with no truncation.

Source files
------------

// File: rtl/selfcon_pkg.sv
// rtl/selfcon_pkg.sv - shared types and constants for the self-convergence controller
package selfcon_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LO,
        S_WAIT_LO,
        S_RUN,
        S_EVAL,
        S_NEXT,
        S_DONE
    } state_t;

    // Speed codes above this threshold use the high offset
    localparam int SPEED_THRESH = 20;
    localparam int OFFSET_LO    = 900;
    localparam int OFFSET_HI    = 1000;
    localparam int SPEED_SCALE  = 10;

    // Scan step multiplier doubles per qualifying run up to this cap
    localparam int                MULT_W   = 11;
    localparam logic [MULT_W-1:0] MULT_CAP = 11'd1024;

endpackage

// File: rtl/selfcon_dmax_eval.sv
// rtl/selfcon_dmax_eval.sv - speed code to delay conversion and convergence compare
module selfcon_dmax_eval
    import selfcon_pkg::*;
#(
    parameter int SPEED_W = 10,
    parameter int DMAX_W  = 14,
    parameter int EPS     = 10
) (
    input  logic [SPEED_W-1:0] speed,
    input  logic [DMAX_W-1:0]  prev,
    output logic [DMAX_W-1:0]  dmax,
    output logic               within_eps
);

    logic [DMAX_W-1:0] scaled;
    logic [DMAX_W-1:0] diff;

    // Convert speed to ps and compare against the previous run's delay
    always_comb begin
        scaled = DMAX_W'(speed) * DMAX_W'(SPEED_SCALE);
        if (speed > SPEED_W'(SPEED_THRESH)) begin
            dmax = scaled + DMAX_W'(OFFSET_HI);
        end else begin
            dmax = scaled + DMAX_W'(OFFSET_LO);
        end
        diff       = (dmax >= prev) ? (dmax - prev) : (prev - dmax);
        within_eps = (diff <= DMAX_W'(EPS));
    end

endmodule

// File: rtl/selfcon_ctrl.sv
// rtl/selfcon_ctrl.sv - BIST run sequencer that repeats runs until delay converges
module selfcon_ctrl
    import selfcon_pkg::*;
#(
    parameter int SIG_W      = 13,
    parameter int SCAN_W     = 20,
    parameter int SPEED_W    = 10,
    parameter int DMAX_W     = 14,
    parameter int SCAN_START = 60,
    parameter int SCAN_BASE  = 10,
    parameter int K          = 8,
    parameter int EPS        = 10,
    parameter int MAX_RUNS   = 24,
    parameter int RST_CYC    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               abort,
    input  logic               over,
    input  logic               scan_done,
    input  logic [SIG_W-1:0]   sig,
    input  logic [SPEED_W-1:0] speed,
    output logic               bist_rst_n,
    output logic               bist_start,
    output logic [SCAN_W-1:0]  scan_num,
    output logic               pass,
    output logic               sig_err,
    output logic [SIG_W-1:0]   golden_sig,
    output logic [DMAX_W-1:0]  dmax,
    output logic [4:0]         run_cnt,
    output logic [3:0]         conv_cnt,
    output logic               done,
    output logic               converged
);

    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_t            state;
    state_t            state_nx;
    logic [RC_W-1:0]   rst_cnt;
    logic [MULT_W-1:0] mult;
    logic [MULT_W-1:0] mult_nx;
    logic              over_q;
    logic              scan_done_q;
    logic              sig_seen;
    logic              last_run;
    logic              over_rise;
    logic              sd_rise;
    logic [DMAX_W-1:0] dmax_new;
    logic              within_eps;
    logic              qualify;
    logic [4:0]        run_nx;
    logic [3:0]        conv_nx;
    logic [SCAN_W:0]   scan_sum;
    logic              hit_conv;
    logic              hit_budget;
    logic              hit_ovf;

    selfcon_dmax_eval #(
        .SPEED_W (SPEED_W),
        .DMAX_W  (DMAX_W),
        .EPS     (EPS)
    ) u_eval (
        .speed      (speed),
        .prev       (dmax),
        .dmax       (dmax_new),
        .within_eps (within_eps)
    );

    assign over_rise = over & ~over_q;
    assign sd_rise   = scan_done & ~scan_done_q;

    // The very first run of a sequence has no previous delay to compare against
    assign qualify   = (run_cnt != 5'd0) && within_eps;
    assign mult_nx   = !qualify ? mult :
                       (mult >= (MULT_CAP >> 1)) ? MULT_CAP : (mult << 1);
    assign run_nx    = run_cnt + 5'd1;
    assign conv_nx   = conv_cnt + {3'd0, qualify};

    // One extra bit on the sum exposes scan_num overflow
    assign scan_sum  = {1'b0, scan_num} + ((SCAN_W+1)'(mult_nx) * (SCAN_W+1)'(SCAN_BASE));
    assign hit_conv   = (conv_nx == 4'(K));
    assign hit_budget = (run_nx == 5'(MAX_RUNS));
    assign hit_ovf    = scan_sum[SCAN_W];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection; abort wins over every other transition
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (go) state_nx = S_RST_LO;
            S_RST_LO:  if (rst_cnt == RC_W'(RST_CYC - 1)) state_nx = S_WAIT_LO;
            S_WAIT_LO: if (!over) state_nx = S_RUN;
            S_RUN:     if (over_rise) state_nx = S_EVAL;
            S_EVAL:    state_nx = S_NEXT;
            S_NEXT:    state_nx = last_run ? S_DONE : S_RST_LO;
            S_DONE:    if (go) state_nx = S_RST_LO;
            default:   state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx = S_IDLE;
        end
    end

    // Edge detectors for the run-complete and unload-complete strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            over_q      <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            over_q      <= over;
            scan_done_q <= scan_done;
        end
    end

    // Run control outputs, signature tracking, delay capture and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            bist_rst_n <= 1'b1;
            bist_start <= 1'b0;
            scan_num   <= SCAN_W'(SCAN_START);
            golden_sig <= '0;
            dmax       <= '0;
            run_cnt    <= '0;
            conv_cnt   <= '0;
            pass       <= 1'b0;
            sig_err    <= 1'b0;
            done       <= 1'b0;
            converged  <= 1'b0;
            mult       <= MULT_W'(1);
            rst_cnt    <= '0;
            sig_seen   <= 1'b0;
            last_run   <= 1'b0;
        end else if (abort) begin
            // sig_err, dmax and the counters stay for readout
            bist_rst_n <= 1'b1;
            bist_start <= 1'b0;
            scan_num   <= SCAN_W'(SCAN_START);
            golden_sig <= '0;
            pass       <= 1'b0;
            done       <= 1'b0;
            converged  <= 1'b0;
            mult       <= MULT_W'(1);
            rst_cnt    <= '0;
            sig_seen   <= 1'b0;
            last_run   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        run_cnt    <= '0;
                        conv_cnt   <= '0;
                        sig_err    <= 1'b0;
                        done       <= 1'b0;
                        converged  <= 1'b0;
                        mult       <= MULT_W'(1);
                        scan_num   <= SCAN_W'(SCAN_START);
                        bist_rst_n <= 1'b0;
                        bist_start <= 1'b1;
                        pass       <= 1'b0;
                        rst_cnt    <= '0;
                        sig_seen   <= 1'b0;
                    end
                end
                S_RST_LO: begin
                    rst_cnt <= rst_cnt + RC_W'(1);
                    if (rst_cnt == RC_W'(RST_CYC - 1)) begin
                        bist_rst_n <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (sd_rise) begin
                        sig_seen <= 1'b1;
                        if (!sig_seen) begin
                            golden_sig <= sig;
                            pass       <= 1'b1;
                        end else begin
                            pass <= (sig == golden_sig);
                            if (sig != golden_sig) begin
                                sig_err <= 1'b1;
                            end
                        end
                    end
                end
                S_EVAL: begin
                    dmax     <= dmax_new;
                    run_cnt  <= run_nx;
                    conv_cnt <= conv_nx;
                    mult     <= mult_nx;
                    last_run <= hit_conv | hit_budget | hit_ovf;
                    if (hit_conv) begin
                        done      <= 1'b1;
                        converged <= 1'b1;
                    end else if (hit_budget) begin
                        done <= 1'b1;
                    end else if (hit_ovf) begin
                        scan_num <= '1;
                        done     <= 1'b1;
                    end else begin
                        scan_num <= scan_sum[SCAN_W-1:0];
                    end
                end
                S_NEXT: begin
                    if (last_run) begin
                        bist_start <= 1'b0;
                    end else begin
                        bist_rst_n <= 1'b0;
                        pass       <= 1'b0;
                        rst_cnt    <= '0;
                        sig_seen   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
